// File: rtl/conv_pkg.sv
// Shared helpers and default widths for the convolution MAC family.
// Provides clog2 and a wide-to-narrow signed saturation helper.
package conv_pkg;

  localparam int PX_W_DEF  = 8;
  localparam int WT_W_DEF  = 8;
  localparam int ACC_W_DEF = 32;
  localparam int OUT_W_DEF = 16;

  typedef struct packed {
    logic signed [63:0] val;
    logic               sat;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Operates on a 64-bit sign-extended accumulator so one helper serves any ACC_W <= 64.
  function automatic sat_t saturate(input logic signed [63:0] v, input int out_w);
    sat_t res;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    res.val = v;
    res.sat = 1'b0;
    if (v > mx) begin
      res.val = mx;
      res.sat = 1'b1;
    end else if (v < mn) begin
      res.val = mn;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_add_tree.sv
// Registered binary adder tree over N signed operands, clog2(N) levels, one register per level.
// Latency clog2(N) cycles; every level holds when en=0 (no bubble compression).
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int N = 10,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_vld,
  input  logic [N*W-1:0]     in_dat,
  output logic               out_vld,
  output logic signed [W-1:0] out_dat
);

  localparam int D = clog2(N);

  function automatic int cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  function automatic int cl(input int x);
    return (x < N) ? x : N - 1;
  endfunction

  logic signed [W-1:0] leaf [N];
  logic signed [W-1:0] stg  [D][N];
  logic signed [W-1:0] nx   [D][N];
  logic [D-1:0]        vld;

  // Level l pairs operands 2j and 2j+1 of level l-1; an odd leftover is carried through.
  always_comb begin
    for (int i = 0; i < N; i++) leaf[i] = in_dat[i*W +: W];
    for (int l = 0; l < D; l++) begin
      for (int j = 0; j < N; j++) begin
        nx[l][j] = '0;
        if (j < cnt(l + 1)) begin
          if (l == 0) begin
            nx[l][j] = leaf[cl(2*j)];
            if (2*j + 1 < cnt(l)) nx[l][j] = leaf[cl(2*j)] + leaf[cl(2*j + 1)];
          end else begin
            nx[l][j] = stg[(l > 0) ? l - 1 : 0][cl(2*j)];
            if (2*j + 1 < cnt(l))
              nx[l][j] = stg[(l > 0) ? l - 1 : 0][cl(2*j)] + stg[(l > 0) ? l - 1 : 0][cl(2*j + 1)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) stg <= nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (en) begin
      vld[0] <= in_vld;
      for (int l = 1; l < D; l++) vld[l] <= vld[l-1];
    end
  end

  assign out_vld = vld[D-1];
  assign out_dat = stg[D-1][0];

endmodule

// File: rtl/conv_mac_pipe.sv
// Pipelined K-tap MAC + bias with saturation; latency clog2(K+1)+2, one global stall enable.
// in_ready = !out_valid || out_ready; optional ReLU after saturation via CONV_MAC_RELU_EN.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int K         = 9,
  parameter int PX_W      = PX_W_DEF,
  parameter int PX_SIGNED = 0,
  parameter int WT_W      = WT_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [K*PX_W-1:0]       in_px,
  input  logic [K*WT_W-1:0]       in_wt,
  input  logic signed [ACC_W-1:0] in_bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int N  = K + 1;
  localparam int PW = PX_W + WT_W + 1;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic signed [ACC_W-1:0] prod_c [K];
  logic signed [ACC_W-1:0] prod_r [K];
  logic signed [ACC_W-1:0] bias_r;
  logic                    s0_vld;

  for (genvar i = 0; i < K; i++) begin : g_tap
    logic [PX_W-1:0]        px;
    logic signed [PX_W:0]   pe;
    logic signed [WT_W-1:0] we;
    logic signed [PW-1:0]   pr;
    assign px = in_px[i*PX_W +: PX_W];
    // The extra pixel bit keeps unsigned pixels non-negative in the signed multiply.
    assign pe = (PX_SIGNED != 0) ? $signed({px[PX_W-1], px}) : $signed({1'b0, px});
    assign we = in_wt[i*WT_W +: WT_W];
    assign pr = pe * we;
    assign prod_c[i] = ACC_W'(pr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s0_vld <= 1'b0;
    else if (adv) s0_vld <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      prod_r <= prod_c;
      bias_r <= in_bias;
    end
  end

  logic [N*ACC_W-1:0]      tree_in;
  logic                    tree_vld;
  logic signed [ACC_W-1:0] tree_sum;

  for (genvar i = 0; i < K; i++) begin : g_leaf
    assign tree_in[i*ACC_W +: ACC_W] = prod_r[i];
  end
  assign tree_in[K*ACC_W +: ACC_W] = bias_r;

  conv_add_tree #(.N(N), .W(ACC_W)) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (adv),
    .in_vld  (s0_vld),
    .in_dat  (tree_in),
    .out_vld (tree_vld),
    .out_dat (tree_sum)
  );

  sat_t                    sr;
  logic signed [OUT_W-1:0] res_c;

  always_comb begin
    sr    = saturate(64'(tree_sum), OUT_W);
    res_c = sr.val[OUT_W-1:0];
`ifdef CONV_MAC_RELU_EN
    if (res_c[OUT_W-1]) res_c = '0;
`else
    res_c = sr.val[OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= tree_vld;
      if (tree_vld) begin
        out_data <= res_c;
        out_sat  <= sr.sat;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Randomized and directed bench for conv_mac_pipe against a plain-arithmetic dot-product model.
module tb_conv_mac_pipe;

  localparam int K = 9, PX_W = 8, PX_SIGNED = 0, WT_W = 8, ACC_W = 32, OUT_W = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [K*PX_W-1:0]       in_px = '0;
  logic [K*WT_W-1:0]       in_wt = '0;
  logic signed [ACC_W-1:0] in_bias = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  always #5 clk = ~clk;

  conv_mac_pipe #(.K(K), .PX_W(PX_W), .PX_SIGNED(PX_SIGNED), .WT_W(WT_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_px(in_px), .in_wt(in_wt),
    .in_bias(in_bias), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  typedef struct { longint d; bit s; } res_t;
  res_t   sbq[$];
  int     total = 0, bad = 0, cyc = 0, ret_cnt = 0, acc_cnt = 0, first_pop = -1, last_pop = 0;
  bit     popped = 0, held = 0, last_s = 0;
  longint held_d = 0, last_d = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [K*PX_W-1:0] px, input logic [K*WT_W-1:0] wt,
                                 input logic [ACC_W-1:0] bias);
    longint sum, p, mx;
    logic [PX_W-1:0] pv;
    logic [WT_W-1:0] wv;
    res_t r;
    sum = longint'($signed(bias));
    for (int i = 0; i < K; i++) begin
      pv = px[i*PX_W +: PX_W];
      wv = wt[i*WT_W +: WT_W];
      if (PX_SIGNED != 0) p = longint'($signed(pv));
      else p = longint'(pv);
      sum += p * longint'($signed(wv));
    end
    mx = (longint'(1) << (OUT_W - 1)) - 1;
    r.d = sum;
    r.s = 0;
    if (sum > mx) begin r.d = mx; r.s = 1; end
    else if (sum < -mx - 1) begin r.d = -mx - 1; r.s = 1; end
`ifdef CONV_MAC_RELU_EN
    if (r.d < 0) r.d = 0;
`endif
    return r;
  endfunction

  // Called just after a negedge with inputs driven; samples, scores, advances one cycle.
  task automatic tick();
    #1;
    popped = 0;
    if (rst_n) begin
      if (held) begin
        chk("hold_vld", out_valid, 1);
        chk("hold_dat", out_data, held_d);
      end
      held = out_valid && !out_ready;
      if (held) held_d = out_data;
      if (in_valid && in_ready) begin
        sbq.push_back(model(in_px, in_wt, in_bias));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        popped = 1;
        if (sbq.size() == 0) chk("spurious_result", 1, 0);
        else begin
          res_t e;
          e = sbq.pop_front();
          chk("sb_dat", out_data, e.d);
          chk("sb_sat", out_sat, e.s);
        end
        last_d = out_data;
        last_s = out_sat;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        ret_cnt++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_beat();
    for (int i = 0; i < K; i++) begin
      in_px[i*PX_W +: PX_W] = PX_W'($urandom);
      in_wt[i*WT_W +: WT_W] = WT_W'($urandom);
    end
    in_bias = ACC_W'(int'($urandom_range(0, 200000)) - 100000);
  endtask

  task automatic set_all(input int px, input int wt, input int bias);
    for (int i = 0; i < K; i++) begin
      in_px[i*PX_W +: PX_W] = PX_W'(px);
      in_wt[i*WT_W +: WT_W] = WT_W'(wt);
    end
    in_bias = ACC_W'(bias);
  endtask

  task automatic send_one(output int lat);
    bit got;
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      lat++;
      tick();
      got = popped;
    end
    if (!got) chk("result_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 0; out_ready = 1; n = 0;
    while (sbq.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, r0, a0, n;
    #3;
    chk("rst_vld", out_valid, 0);
    chk("rst_dat", out_data, 0);
    chk("rst_sat", out_sat, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    set_all(255, -128, 0);
    send_one(lat);
    chk("t1_dat", last_d, -32768);
    chk("t1_sat", last_s, 1);

    for (int i = 0; i < K; i++) begin
      in_px[i*PX_W +: PX_W] = PX_W'(i + 1);
      in_wt[i*WT_W +: WT_W] = WT_W'(1);
    end
    in_bias = 5;
    send_one(lat);
    chk("t2_dat", last_d, 50);
    chk("t2_sat", last_s, 0);
    chk("t2_lat", lat, 6);

    set_all(10, -1, 0);
    send_one(lat);
`ifdef CONV_MAC_RELU_EN
    chk("t6_dat", last_d, 0);
`else
    chk("t6_dat", last_d, -90);
`endif
    chk("t6_sat", last_s, 0);

    r0 = ret_cnt; first_pop = -1;
    for (int i = 0; i < 20; i++) begin
      rand_beat(); in_valid = 1; out_ready = 1;
      #1 chk("t3_rdy", in_ready, 1);
      tick();
    end
    drain();
    chk("t3_cnt", ret_cnt - r0, 20);
    chk("t3_span", last_pop - first_pop + 1, 20);

    for (int i = 0; i < 8; i++) begin
      rand_beat(); in_valid = 1; out_ready = 1;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      rand_beat(); in_valid = 1; out_ready = 0;
      #1 chk("t4_rdy_low", in_ready, 0);
      tick();
    end
    rand_beat(); in_valid = 1; out_ready = 1;
    #1 chk("t4_rdy_rel", in_ready, 1);
    a0 = acc_cnt; r0 = ret_cnt;
    tick();
    chk("t4_acc", acc_cnt - a0, 1);
    chk("t4_ret", ret_cnt - r0, 1);
    drain();

    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rand_beat(); in_valid = 1;
      tick();
    end
    in_valid = 0; n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t5_vld_up", out_valid, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_vld", out_valid, 0);
    chk("t5_rst_sat", out_sat, 0);
    sbq.delete(); held = 0;
    tick(); tick();
    rst_n = 1; out_ready = 1; r0 = ret_cnt;
    for (int i = 0; i < 12; i++) tick();
    chk("t5_stale", ret_cnt - r0, 0);
    for (int i = 0; i < K; i++) begin
      in_px[i*PX_W +: PX_W] = PX_W'(i + 1);
      in_wt[i*WT_W +: WT_W] = WT_W'(1);
    end
    in_bias = 5;
    send_one(lat);
    chk("t5_dat", last_d, 50);
    chk("t5_lat", lat, 6);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) begin rand_beat(); in_valid = 1; end
      else in_valid = 0;
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
